unary_add_sequencer: RTL and testbench

UNARY_ADD_SEQUENCER -- requirements
Module: unary_add_sequencer

---
 rtl/unary_ctrl_pkg.sv | 16 +
 rtl/unary_add_sequencer_bin_to_unary.sv | 29 ++
 rtl/unary_add_sequencer.sv | 142 ++++++++++++++
 tb/tb_unary_add_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/unary_ctrl_pkg.sv
// Shared control types for the unary add sequencer: FSM state encoding and
// the unary stream length derived from the binary operand width.
package unary_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Longest unary stream a BIN_BITS-wide operand pair can produce, plus margin.
  function automatic int u_bits(input int bin_bits);
    return 32'sd1 << (bin_bits + 32'sd1);
  endfunction

endpackage

// File: rtl/unary_add_sequencer_bin_to_unary.sv
// Binary-to-unary converter: loads a count and emits a 1 each enabled cycle
// while the remaining count is nonzero, counting down by one per cycle.
module bin_to_unary #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         nonzero
);

  logic [W-1:0] rem_r;

  // Remaining-count register: load, then count down while enabled and nonzero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_r <= '0;
    end else if (load) begin
      rem_r <= value;
    end else if (en && (rem_r != '0)) begin
      rem_r <= rem_r - W'(1);
    end
  end

  assign nonzero = (rem_r != '0);

endmodule

// File: rtl/unary_add_sequencer.sv
// Feeds two binary operands as unary pulse streams into an external adder,
// measures the returned sum pulse and reports its binary length with a check.
module unary_add_sequencer
  import unary_ctrl_pkg::*;
#(
  parameter int BIN_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_BITS-1:0] in_a,
  input  logic [BIN_BITS-1:0] in_b,
  output logic                add_a,
  output logic                add_b,
  input  logic                add_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [BIN_BITS:0]   res_sum,
  output logic                res_err
);

  localparam int SW     = BIN_BITS + 1;
  localparam int U_BITS = u_bits(BIN_BITS);

  state_e        state_r;
  state_e        state_next_s;
  logic          a_nz_s;
  logic          b_nz_s;
  logic          load_s;
  logic          run_s;
  logic          done_s;
  logic          timeout_s;
  logic [SW-1:0] sum_cnt_r;
  logic [SW-1:0] run_cnt_r;
  logic [SW-1:0] sum_exp_r;
  logic [SW-1:0] res_sum_r;
  logic          res_err_r;

  bin_to_unary #(.W(BIN_BITS)) u_conv_a (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_s),
    .en      (run_s),
    .value   (in_a),
    .nonzero (a_nz_s)
  );

  bin_to_unary #(.W(BIN_BITS)) u_conv_b (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_s),
    .en      (run_s),
    .value   (in_b),
    .nonzero (b_nz_s)
  );

  // Normal completion needs both streams drained and the sum pulse ended.
  assign done_s    = !a_nz_s && !b_nz_s && !add_out;
  assign timeout_s = (run_cnt_r == SW'(U_BITS - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_next_s = ST_RUN;
        else          state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (done_s || timeout_s) state_next_s = ST_RESP;
        else                     state_next_s = ST_RUN;
      end
      ST_RESP: begin
        if (res_ready) state_next_s = ST_IDLE;
        else           state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    run_s     = 1'b0;
    case (state_r)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  run_s     = 1'b1;
      ST_RESP: res_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
    load_s = in_ready && in_valid;
    add_a  = run_s && a_nz_s;
    add_b  = run_s && b_nz_s;
  end

  // Run/sum counters and expected sum, armed on operand acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_r <= '0;
      sum_cnt_r <= '0;
      sum_exp_r <= '0;
    end else if (load_s) begin
      run_cnt_r <= '0;
      sum_cnt_r <= '0;
      sum_exp_r <= SW'(in_a) + SW'(in_b);
    end else if (run_s) begin
      run_cnt_r <= run_cnt_r + SW'(1);
      if (add_out && (sum_cnt_r != '1)) begin
        sum_cnt_r <= sum_cnt_r + SW'(1);
      end
    end
  end

  // Result capture on leaving RUN; held untouched through RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_sum_r <= '0;
      res_err_r <= 1'b0;
    end else if (run_s && done_s) begin
      res_sum_r <= sum_cnt_r;
      res_err_r <= (sum_cnt_r != sum_exp_r);
    end else if (run_s && timeout_s) begin
      res_sum_r <= '1;
      res_err_r <= 1'b1;
    end
  end

  assign res_sum = res_sum_r;
  assign res_err = res_err_r;

endmodule

// File: tb/tb_unary_add_sequencer.sv
// Directed bench for unary_add_sequencer with a behavioural unary adder that
// can be forced stuck low or stuck high.
module tb_unary_add_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       add_a;
  logic       add_b;
  logic       add_out;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_sum;
  logic       res_err;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  int acc;

  unary_add_sequencer #(.BIN_BITS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  // Unary adder model: pending pulses accumulate, output high while any remain.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)            acc <= 0;
    else if (fault_mode != 0) acc <= 0;
    else acc <= acc + int'(add_a) + int'(add_b) - int'(add_out);
  end

  always_comb begin
    add_out = 1'b0;
    if (fault_mode == 1)      add_out = 1'b0;
    else if (fault_mode == 2) add_out = 1'b1;
    else                      add_out = ((acc + int'(add_a) + int'(add_b)) != 0);
  end

  // Offer a pair in cycle 0 and watch the streams until res_valid or budget.
  task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input int budget,
                           output int vcyc, output int a_cnt, output int a_first, output int a_last,
                           output int b_cnt, output int b_first, output int b_last);
    in_a = a; in_b = b; in_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 4'hF; in_b = 4'hF;
    vcyc = -1; a_cnt = 0; a_first = -1; a_last = -1; b_cnt = 0; b_first = -1; b_last = -1;
    for (int c = 1; c <= budget && vcyc < 0; c++) begin
      @(negedge clk);
      if (add_a) begin a_cnt++; if (a_first < 0) a_first = c; a_last = c; end
      if (add_b) begin b_cnt++; if (b_first < 0) b_first = c; b_last = c; end
      if (res_valid) vcyc = c;
      else begin @(posedge clk); #1; end
    end
  endtask

  // Take the result, then land mid-cycle in the following cycle.
  task automatic ack_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_a = 4'd0; in_b = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if ({add_a, add_b} !== 2'b00) begin errors++; $display("FAIL reset_add got %b want 00", {add_a, add_b}); end
    checks++; if (res_sum !== 5'd0) begin errors++; $display("FAIL reset_res_sum got %0d want 0", res_sum); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err got %b want 0", res_err); end
  endtask

  task automatic test_basic();
    int v, ac, af, al, bc, bf, bl;
    send_pair(4'd3, 4'd5, 40, v, ac, af, al, bc, bf, bl);
    checks++; if (v !== 10) begin errors++; $display("FAIL basic_valid_cycle got %0d want 10", v); end
    checks++; if ({ac, af, al} !== {32'd3, 32'd1, 32'd3}) begin errors++; $display("FAIL basic_add_a cnt/first/last got %0d/%0d/%0d want 3/1/3", ac, af, al); end
    checks++; if ({bc, bf, bl} !== {32'd5, 32'd1, 32'd5}) begin errors++; $display("FAIL basic_add_b cnt/first/last got %0d/%0d/%0d want 5/1/5", bc, bf, bl); end
    checks++; if (res_sum !== 5'd8) begin errors++; $display("FAIL basic_sum got %0d want 8", res_sum); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", res_err); end
    ack_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_zero();
    int v, ac, af, al, bc, bf, bl;
    send_pair(4'd0, 4'd0, 40, v, ac, af, al, bc, bf, bl);
    checks++; if (v !== 2) begin errors++; $display("FAIL zero_valid_cycle got %0d want 2", v); end
    checks++; if (ac + bc !== 0) begin errors++; $display("FAIL zero_streams got %0d high cycles want 0", ac + bc); end
    checks++; if (res_sum !== 5'd0) begin errors++; $display("FAIL zero_sum got %0d want 0", res_sum); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL zero_err got %b want 0", res_err); end
    ack_result();
  endtask

  task automatic test_max();
    int v, ac, af, al, bc, bf, bl;
    send_pair(4'd15, 4'd15, 40, v, ac, af, al, bc, bf, bl);
    checks++; if (v !== 32) begin errors++; $display("FAIL max_valid_cycle got %0d want 32", v); end
    checks++; if (res_sum !== 5'd30) begin errors++; $display("FAIL max_sum got %0d want 30", res_sum); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL max_err got %b want 0", res_err); end
    ack_result();
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [3] = '{4'd1, 4'd4, 4'd0};
    logic [3:0] vb [3] = '{4'd1, 4'd0, 4'd9};
    int         ev [3] = '{4, 6, 11};
    logic [4:0] es [3] = '{5'd2, 5'd4, 5'd9};
    int v, ac, af, al, bc, bf, bl;
    for (int i = 0; i < 3; i++) begin
      send_pair(va[i], vb[i], 40, v, ac, af, al, bc, bf, bl);
      checks++; if (v !== ev[i]) begin errors++; $display("FAIL b2b%0d_valid_cycle got %0d want %0d", i, v, ev[i]); end
      checks++; if (res_sum !== es[i] || res_err !== 1'b0) begin errors++; $display("FAIL b2b%0d_result got %0d/%b want %0d/0", i, res_sum, res_err, es[i]); end
      ack_result();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready_after got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int v, ac, af, al, bc, bf, bl;
    send_pair(4'd2, 4'd3, 40, v, ac, af, al, bc, bf, bl);
    checks++; if (v !== 7) begin errors++; $display("FAIL bp_valid_cycle got %0d want 7", v); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 4'(i + 7); in_b = 4'(i + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if ({res_valid, in_ready, res_sum, res_err} !== {1'b1, 1'b0, 5'd5, 1'b0})
        begin errors++; $display("FAIL bp_hold%0d valid/ready/sum/err got %b/%b/%0d/%b want 1/0/5/0", i, res_valid, in_ready, res_sum, res_err); end
    end
    ack_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", in_ready); end
    ac = 0;
    repeat (4) begin @(negedge clk); if (add_a || add_b || !in_ready) ac++; end
    checks++; if (ac !== 0) begin errors++; $display("FAIL bp_ignored_pulses got %0d busy cycles want 0", ac); end
  endtask

  task automatic test_faults();
    int v, ac, af, al, bc, bf, bl;
    fault_mode = 1;
    send_pair(4'd2, 4'd1, 40, v, ac, af, al, bc, bf, bl);
    checks++; if (v !== 4) begin errors++; $display("FAIL stuck_low_valid_cycle got %0d want 4", v); end
    checks++; if (res_sum !== 5'd0 || res_err !== 1'b1) begin errors++; $display("FAIL stuck_low_result got %0d/%b want 0/1", res_sum, res_err); end
    ack_result();
    fault_mode = 2;
    send_pair(4'd1, 4'd1, 60, v, ac, af, al, bc, bf, bl);
    checks++; if (v !== 33) begin errors++; $display("FAIL stuck_high_valid_cycle got %0d want 33", v); end
    checks++; if (res_sum !== 5'd31 || res_err !== 1'b1) begin errors++; $display("FAIL stuck_high_result got %0d/%b want 31/1", res_sum, res_err); end
    ack_result();
    fault_mode = 0;
  endtask

  task automatic test_reset_midrun();
    int v, ac, af, al, bc, bf, bl;
    in_a = 4'd7; in_b = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({add_a, add_b} !== 2'b11) begin errors++; $display("FAIL midrun_streams_before got %b want 11", {add_a, add_b}); end
    reset_n = 1'b0; #1;
    checks++; if ({add_a, add_b, res_valid} !== 3'b000) begin errors++; $display("FAIL midrun_reset_outputs got %b want 000", {add_a, add_b, res_valid}); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || add_a !== 1'b0) begin errors++; $display("FAIL midrun_idle_after ready/add_a got %b/%b want 1/0", in_ready, add_a); end
    send_pair(4'd1, 4'd2, 40, v, ac, af, al, bc, bf, bl);
    checks++; if (v !== 5) begin errors++; $display("FAIL midrun_next_valid_cycle got %0d want 5", v); end
    checks++; if (res_sum !== 5'd3 || res_err !== 1'b0) begin errors++; $display("FAIL midrun_next_result got %0d/%b want 3/0", res_sum, res_err); end
    ack_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_faults();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
